// File: rtl/operand_fetch.sv
// Decode-stage operand fetch: register-file read addressing, EX/MEM/WB bypass
// select, load-use hazard detection and the D->E pipeline register.
module operand_fetch #(
  parameter int CTRL_W    = 16,
  parameter bit WB_BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [4:0]        ra1,
  output logic [4:0]        ra2,
  input  logic [31:0]       rd1,
  input  logic [31:0]       rd2,
  input  logic              ex_regwrite,
  input  logic              ex_is_load,
  input  logic [4:0]        ex_wa,
  input  logic [31:0]       ex_result,
  input  logic              mem_regwrite,
  input  logic [4:0]        mem_wa,
  input  logic [31:0]       mem_result,
  input  logic              wb_regwrite,
  input  logic [4:0]        wb_wa,
  input  logic [31:0]       wb_result,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       op_a,
  output logic [31:0]       op_b,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [31:0]       stall_cnt
);

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic        hazard;
  logic        advance;
  logic        load_pending;

  // Youngest producer first; a load still in EX has no result yet and is skipped.
  function automatic logic [31:0] select_operand(input logic [4:0] src, input logic [31:0] file_data);
    logic [31:0] result;
    result = file_data;
    if (src == 5'd0)
      result = 32'd0;
    else if (ex_regwrite && !ex_is_load && ex_wa == src)
      result = ex_result;
    else if (mem_regwrite && mem_wa == src)
      result = mem_result;
    else if (WB_BYPASS && wb_regwrite && wb_wa == src)
      result = wb_result;
    return result;
  endfunction

  assign ra1 = rs;
  assign ra2 = rt;

  always_comb begin
    fwd_a = select_operand(rs, rd1);
    fwd_b = select_operand(rt, rd2);
  end

  assign load_pending = ex_regwrite && ex_is_load && (ex_wa != 5'd0);
  assign hazard       = load_pending && ((use_rs && rs == ex_wa) || (use_rt && rt == ex_wa));
  assign advance      = !out_valid || out_ready;
  assign in_ready     = advance && !hazard && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      ctrl_out  <= '0;
      stall_cnt <= 32'd0;
    end else begin
      // Counted even under backpressure: the instruction is still waiting on the load.
      if (in_valid && hazard && !flush)
        stall_cnt <= stall_cnt + 32'd1;

      if (flush) begin
        out_valid <= 1'b0;
      end else if (advance) begin
        if (in_valid && !hazard) begin
          op_a      <= fwd_a;
          op_b      <= fwd_b;
          ctrl_out  <= ctrl_in;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule
